fetch_ctrl: RTL

Sequences the instruction memory for the RISC-V pipeline's IF stage. Holds the PC, drives the word address into the combinational-read instruction memory, and captures the returned word into the IF/ID register. Handles stall, branch/jump redirect, EBREAK halt and out-of-range/misaligned faults. Sits between the instruction memory and the decode stage; stall and redirect come from the hazard unit and EX stage.

---
 rtl/fetch_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module   : fetch_ctrl
// Brief    : IF-stage sequencer: PC, imem word address, IF/ID capture,
//            stall / redirect / EBREAK halt / fault handling.
//            Optional build macro FETCH_PERF_CNT_EN adds fetch/stall counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 51,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [29:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o,
    output logic        halted_o,
    output logic        fault_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam logic [1:0]  S_BOOT  = 2'd0;
    localparam logic [1:0]  S_RUN   = 2'd1;
    localparam logic [1:0]  S_HALT  = 2'd2;
    localparam logic [1:0]  S_FAULT = 2'd3;

    localparam logic [31:0] C_EBREAK    = 32'h0010_0073;
    localparam logic [29:0] C_MEM_WORDS = MEM_WORDS[29:0];

    logic [1:0]  state_q,  state_d;
    logic [31:0] pc_q,     pc_d;
    logic [31:0] pc_o_q,   pc_o_d;
    logic [31:0] inst_q,   inst_d;
    logic        valid_q,  valid_d;
    logic        halted_q, halted_d;
    logic        fault_q,  fault_d;

    logic        w_redir_ok;
    logic        w_redir_bad;
    logic        w_oor;
    logic        w_ebreak;
    logic        w_fetch;

    assign w_redir_ok  = redirect_i && (redirect_pc_i[1:0] == 2'b00);
    assign w_redir_bad = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign w_oor       = (pc_q[31:2] >= C_MEM_WORDS);
    assign w_ebreak    = (imem_rdata_i == C_EBREAK);
    // A real instruction enters IF/ID only on an unstalled, unredirected in-range RUN cycle.
    assign w_fetch     = (state_q == S_RUN) && !redirect_i && !stall_i && !w_oor;

    // ------------------------------------------------------------------------
    // State and IF/ID registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_BOOT;
            pc_q     <= RESET_PC;
            pc_o_q   <= 32'h0000_0000;
            inst_q   <= NOP_INST;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_o_q   <= pc_o_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (w_redir_bad) begin
                    state_d = S_FAULT;
                end else if (w_redir_ok || stall_i) begin
                    state_d = S_RUN;
                end else if (w_oor) begin
                    state_d = S_FAULT;
                end else if (w_ebreak) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (w_redir_ok) begin
                    state_d = S_RUN;
                end else if (w_redir_bad) begin
                    state_d = S_FAULT;
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------------
    always_comb begin
        pc_d     = pc_q;
        pc_o_d   = pc_o_q;
        inst_d   = inst_q;
        valid_d  = valid_q;
        halted_d = (state_d == S_HALT);
        fault_d  = (state_d == S_FAULT);

        case (state_q)
            S_RUN, S_HALT: begin
                if (redirect_i) begin
                    // Every redirect leaves one bubble; only aligned targets move the PC.
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                    if (w_redir_ok) begin
                        pc_d = redirect_pc_i;
                    end
                end else if (stall_i) begin
                    pc_d = pc_q;
                end else if (state_q == S_HALT || w_oor) begin
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                end else if (w_fetch) begin
                    pc_o_d  = pc_q;
                    inst_d  = imem_rdata_i;
                    valid_d = 1'b1;
                    if (!w_ebreak) begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    assign imem_addr_o = pc_q[31:2];
    assign pc_o        = pc_o_q;
    assign inst_o      = inst_q;
    assign valid_o     = valid_q;
    assign halted_o    = halted_q;
    assign fault_o     = fault_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'h0000_0000;
            stall_cnt_q <= 32'h0000_0000;
        end else begin
            if (w_fetch) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if ((state_q == S_RUN) && stall_i && !redirect_i) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

`default_nettype wire
